// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter_pkg
//  Purpose  : Shared owner/side encodings for the I/D memory arbiter.
//  Revision : 1.0
// ============================================================================
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef struct packed {
        owner_e owner;
        logic   is_write;
    } resp_t;

    function automatic owner_e owner_of(input logic [1:0] gnt);
        owner_e o;
        o = OWN_NONE;
        if (gnt[0])      o = OWN_I;
        else if (gnt[1]) o = OWN_D;
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-way round-robin arbiter; bit 0 is I, bit 1 is D.
//  Revision : 1.0
// ============================================================================
module rr_arbiter2
    import imem_dmem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // On conflict the side that did not win last time goes first.
                2'b11:   gnt_o = (last_q == SIDE_D) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o[0])      last_d = SIDE_I;
        else if (gnt_o[1]) last_d = SIDE_D;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= SIDE_D;
        else       last_q <= last_d;
    end

    assign last_o = last_q;

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Purpose  : Shares one single-port BRAM between fetch (I) and LSU (D).
//  Revision : 1.0
// ============================================================================
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_read,
    input  logic [ADDRESS_BITS-1:0] i_address,
    output logic                    i_grant,
    output logic                    i_resp_valid,
    output logic [DATA_WIDTH-1:0]   i_resp_data,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDRESS_BITS-1:0] d_address,
    input  logic [DATA_WIDTH-1:0]   d_in_data,
    output logic                    d_grant,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_in_data,
    input  logic [DATA_WIDTH-1:0]   mem_out_data,
    input  logic                    report
);

    logic [1:0]  req_vec;
    logic [1:0]  gnt;
    logic        last_side;
    logic        arb_en;
    logic        rst_hold_q;
    resp_t       resp_q;
    resp_t       resp_d;
    logic [31:0] cycles_q;
    logic [31:0] i_grants_q;
    logic [31:0] d_grants_q;

    assign req_vec = {d_read | d_write, i_read};
    // Grants stay off in the reset cycle and the one after it.
    assign arb_en  = !reset && !rst_hold_q;

    rr_arbiter2 u_arb (
        .clk_i  (clock),
        .rst_i  (reset),
        .en_i   (arb_en),
        .req_i  (req_vec),
        .gnt_o  (gnt),
        .last_o (last_side)
    );

    assign i_grant = gnt[0];
    assign d_grant = gnt[1];

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_in_data = '0;
        if (gnt[0]) begin
            mem_read    = 1'b1;
            mem_address = i_address;
        end else if (gnt[1]) begin
            mem_address = d_address;
            if (d_write) begin
                mem_write   = 1'b1;
                mem_in_data = d_in_data;
            end else begin
                mem_read    = 1'b1;
            end
        end
    end

    always_comb begin
        resp_d.owner    = owner_of(gnt);
        resp_d.is_write = gnt[1] & d_write;
    end

    always_comb begin
        i_resp_valid = 1'b0;
        i_resp_data  = '0;
        d_resp_valid = 1'b0;
        d_resp_data  = '0;
        if (!reset) begin
            case (resp_q.owner)
                OWN_I: begin
                    i_resp_valid = 1'b1;
                    i_resp_data  = mem_out_data;
                end
                OWN_D: begin
                    d_resp_valid = 1'b1;
                    if (!resp_q.is_write) d_resp_data = mem_out_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rst_hold_q <= 1'b1;
            resp_q     <= '{owner: OWN_NONE, is_write: 1'b0};
            cycles_q   <= '0;
            i_grants_q <= '0;
            d_grants_q <= '0;
        end else begin
            rst_hold_q <= 1'b0;
            resp_q     <= resp_d;
            cycles_q   <= cycles_q + 32'd1;
            i_grants_q <= i_grants_q + {31'd0, gnt[0]};
            d_grants_q <= d_grants_q + {31'd0, gnt[1]};
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report) begin
            $display("core %0d: cycles=%0d last_grant=%s resp_owner=%0d i_grants=%0d d_grants=%0d",
                     CORE, cycles_q, (last_side == SIDE_D) ? "D" : "I",
                     resp_q.owner, i_grants_q, d_grants_q);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_dmem_arbiter
//  Purpose  : Directed bench with a cycle-level reference model and BRAM.
//  Revision : 1.0
// ============================================================================
module tb_imem_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_read;
    logic [10:0] i_address;
    logic        i_grant;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        d_read;
    logic        d_write;
    logic [10:0] d_address;
    logic [31:0] d_in_data;
    logic        d_grant;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        mem_read;
    logic        mem_write;
    logic [10:0] mem_address;
    logic [31:0] mem_in_data;
    logic [31:0] mem_out_data = 32'd0;
    logic        report;

    int checks = 0;
    int errors = 0;

    imem_dmem_arbiter #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(11)) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_grant(i_grant),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_in_data(d_in_data), .d_grant(d_grant),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_in_data(mem_in_data), .mem_out_data(mem_out_data),
        .report(report)
    );

    always #5 clock = ~clock;

    // BRAM driven by the DUT; gold is the model's own view of memory contents.
    logic [31:0] bram [0:2047];
    logic [31:0] gold [0:2047];

    always @(posedge clock) begin
        if (mem_write) bram[mem_address] <= mem_in_data;
        if (mem_read)  mem_out_data      <= bram[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: side 0 = none, 1 = I, 2 = D.
    logic        m_last_d   = 1'b1;
    logic        m_prev_rst = 1'b1;
    int          m_pend     = 0;
    logic        m_pend_wr  = 1'b0;
    logic [31:0] m_pend_dat = 32'd0;
    int          e_side     = 0;
    logic        e_wr       = 1'b0;
    logic [10:0] e_addr     = 11'd0;
    logic [31:0] e_wdata    = 32'd0;

    always @(negedge clock) begin
        logic ri, rd;
        int   side;
        ri = i_read;
        rd = d_read | d_write;
        if (reset || m_prev_rst) side = 0;
        else if (ri && rd)       side = m_last_d ? 1 : 2;
        else if (ri)             side = 1;
        else if (rd)             side = 2;
        else                     side = 0;
        e_side  = side;
        e_wr    = (side == 2) && d_write;
        e_addr  = (side == 1) ? i_address : (side == 2) ? d_address : 11'd0;
        e_wdata = e_wr ? d_in_data : 32'd0;

        chk("i_grant",     32'(i_grant),     32'(side == 1));
        chk("d_grant",     32'(d_grant),     32'(side == 2));
        chk("mem_read",    32'(mem_read),    32'((side != 0) && !e_wr));
        chk("mem_write",   32'(mem_write),   32'(e_wr));
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_in_data", mem_in_data,      e_wdata);

        chk("i_resp_valid", 32'(i_resp_valid), 32'(!reset && m_pend == 1));
        chk("i_resp_data",  i_resp_data,  (!reset && m_pend == 1) ? m_pend_dat : 32'd0);
        chk("d_resp_valid", 32'(d_resp_valid), 32'(!reset && m_pend == 2));
        chk("d_resp_data",  d_resp_data,  (!reset && m_pend == 2 && !m_pend_wr) ? m_pend_dat : 32'd0);
    end

    always @(posedge clock) begin
        if (reset) begin
            m_last_d   <= 1'b1;
            m_prev_rst <= 1'b1;
            m_pend     <= 0;
            m_pend_wr  <= 1'b0;
            m_pend_dat <= 32'd0;
        end else begin
            m_prev_rst <= 1'b0;
            if (e_side != 0) m_last_d <= (e_side == 2);
            m_pend     <= e_side;
            m_pend_wr  <= e_wr;
            m_pend_dat <= e_wr ? 32'd0 : gold[e_addr];
            if (e_wr) gold[e_addr] <= e_wdata;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dw;
        logic [10:0] ia;
        logic [10:0] da;
        logic [31:0] dd;
    } vec_t;

    vec_t vecs [12];
    logic [31:0] c0;

    initial begin
        for (int a = 0; a < 2048; a++) begin
            bram[a] = 32'd0;
            gold[a] = 32'd0;
        end
        bram[4] = 32'h0000_0013;
        gold[4] = 32'h0000_0013;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 11'h004, 11'h030, 32'hA5A5_0001};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 11'h010, 11'h030, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 11'h020, 11'h004, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h031, 32'h0BAD_F00D};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 11'h031, 11'h000, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 11'h7FF, 11'h7FF, 32'hFFFF_FFFF};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 11'h030, 11'h7FF, 32'hCAFE_0007};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 11'h7FF, 11'h7FF, 32'h1111_2222};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 11'h7FF, 11'h030, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 11'h000, 11'h031, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 11'h010, 11'h000, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 11'h000, 11'h000, 32'h0};

        reset = 1'b1; report = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_in_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Fetch alone
        i_read = 1'b1; i_address = 11'h004;
        @(negedge clock);
        chk("ionly_grant", 32'(i_grant), 32'd1);
        chk("ionly_addr",  32'(mem_address), 32'h004);
        tick();
        i_read = 1'b0;
        @(negedge clock);
        chk("ionly_resp_valid", 32'(i_resp_valid), 32'd1);
        chk("ionly_resp_data",  i_resp_data, 32'h0000_0013);

        // Reset one cycle after a grant swallows the response
        tick();
        i_read = 1'b1; i_address = 11'h008;
        @(negedge clock);
        chk("pre_reset_grant", 32'(i_grant), 32'd1);
        tick();
        reset = 1'b1; i_read = 1'b0;
        @(negedge clock);
        chk("reset_resp_dropped", 32'(i_resp_valid), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("cycles_cleared",   dut.cycles_q,   32'd0);
        chk("i_grants_cleared", dut.i_grants_q, 32'd0);
        chk("d_grants_cleared", dut.d_grants_q, 32'd0);
        tick();

        // Continuous conflict alternates starting with I
        i_read = 1'b1; d_read = 1'b1; i_address = 11'h004; d_address = 11'h010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("conflict_i_grant", 32'(i_grant), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("conflict_d_grant", 32'(d_grant), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        i_read = 1'b0; d_read = 1'b0;
        @(negedge clock);
        chk("conflict_i_grants", dut.i_grants_q, 32'd2);
        chk("conflict_d_grants", dut.d_grants_q, 32'd2);
        chk("conflict_last_resp_d", 32'(d_resp_valid), 32'd1);

        // Store then load back-to-back
        tick();
        d_write = 1'b1; d_address = 11'h010; d_in_data = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("store_mem_write", 32'(mem_write), 32'd1);
        tick();
        d_write = 1'b0; d_read = 1'b1;
        @(negedge clock);
        chk("store_ack_valid", 32'(d_resp_valid), 32'd1);
        chk("store_ack_data",  d_resp_data, 32'd0);
        tick();
        d_read = 1'b0;
        @(negedge clock);
        chk("load_data", d_resp_data, 32'hDEAD_BEEF);

        // Read and write together behave as a write
        tick();
        d_read = 1'b1; d_write = 1'b1; d_address = 11'h020; d_in_data = 32'h1234_5678;
        @(negedge clock);
        chk("rw_mem_write", 32'(mem_write), 32'd1);
        chk("rw_mem_read",  32'(mem_read),  32'd0);
        tick();
        d_write = 1'b0;
        tick();
        d_read = 1'b0;
        @(negedge clock);
        chk("rw_readback", d_resp_data, 32'h1234_5678);

        // Idle cycles
        tick();
        @(negedge clock);
        c0 = dut.cycles_q;
        tick(); tick(); tick();
        @(negedge clock);
        chk("idle_cycles_delta", dut.cycles_q, c0 + 32'd3);
        chk("idle_mem_addr", 32'(mem_address), 32'd0);

        // Mixed directed vectors, checked by the model every cycle
        for (int v = 0; v < 12; v++) begin
            tick();
            i_read    = vecs[v].ir;
            d_read    = vecs[v].dr;
            d_write   = vecs[v].dw;
            i_address = vecs[v].ia;
            d_address = vecs[v].da;
            d_in_data = vecs[v].dd;
            report    = (v == 11);
        end
        tick();
        report = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port BRAM-backed memory interface between two requesters: instruction fetch (port I, read-only) and load/store unit (port D, read/write).
- Grants at most one access per cycle using round-robin on conflict.
- Returns read data to the owning requester one cycle after grant, matching the BRAM's one-cycle registered read.
- Sits between the 5-stage pipeline's fetch/memory stages and a unified memory interface instance.

Parameters:
- CORE, 0, core ID printed in report output.
- DATA_WIDTH, 32, data bus width.
- ADDRESS_BITS, 11, word address width.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous active-high reset
- i_read  input  1  fetch read request, held until granted
- i_address  input  ADDRESS_BITS  fetch address
- i_grant  output  1  fetch request accepted this cycle
- i_resp_valid  output  1  i_resp_data valid this cycle
- i_resp_data  output  DATA_WIDTH  fetch read data
- d_read  input  1  load request, held until granted
- d_write  input  1  store request, held until granted
- d_address  input  ADDRESS_BITS  load/store address
- d_in_data  input  DATA_WIDTH  store data
- d_grant  output  1  D request accepted this cycle
- d_resp_valid  output  1  load data valid, or store acknowledged
- d_resp_data  output  DATA_WIDTH  load read data
- mem_read  output  1  to memory read
- mem_write  output  1  to memory write
- mem_address  output  ADDRESS_BITS  to memory address
- mem_in_data  output  DATA_WIDTH  to memory write data
- mem_out_data  input  DATA_WIDTH  from memory, valid one cycle after mem_read
- report  input  1  print state and counters on this clock edge

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous and active-high.
- Request decode:
  - req_i = i_read; req_d = d_read | d_write.
  - If d_read and d_write are both high, the access is treated as a write and the read is ignored.
- Grant logic (combinational, same cycle):
  - Only req_i → grant I.
  - Only req_d → grant D.
  - Both → grant the side opposite to last_grant.
  - Neither → no grant, and mem_read = mem_write = 0, mem_address = 0, mem_in_data = 0.
- Memory drive by grant:
  - Grant I: mem_read = 1, mem_address = i_address.
  - Grant D read: mem_read = 1, mem_address = d_address.
  - Grant D write: mem_write = 1, mem_address = d_address, mem_in_data = d_in_data.
- last_grant register:
  - Updated only on a cycle with a grant.
  - Reset value is D, so the first conflict after reset goes to I.
- Response pipeline:
  - resp_owner register holds {none, I, D} plus a resp_is_write flag, captured at grant.
  - Cycle N+1 after a grant in cycle N:
    - Owner I → i_resp_valid = 1, i_resp_data = mem_out_data.
    - Owner D read → d_resp_valid = 1, d_resp_data = mem_out_data.
    - Owner D write → d_resp_valid = 1, d_resp_data = 0.
  - Latency: exactly 1 cycle from grant to resp_valid.
  - Throughput: 1 access per cycle. Back-to-back grants are allowed because the pipeline is 1 deep and fully overlapped.
- Non-owner outputs: resp_valid = 0, resp_data = 0.
- Starvation bound: under continuous dual requests, grants alternate I, D, I, D, ... No requester waits more than 1 cycle.
- Counters:
  - cycles, i_grants, d_grants: 32 bits each, wrapping modulo 2^32.
  - Reset to 0.
- Reset:
  - Outputs: all grant and resp outputs are 0 in the reset cycle and the cycle after.
  - State: resp_owner = none, last_grant = D, counters cleared.
  - A grant issued in the cycle before reset produces no response.
  - Requests present during reset are not granted.
- Report: when report is high, $display CORE, cycles, last_grant, resp_owner, and the three counters.

Decomposition:
- Shared package:
  - Owner encoding OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2.
  - Grant-side constant SIDE_I = 1'b0, SIDE_D = 1'b1.
- Sub-module rr_arbiter2 (2-way round-robin: req[1:0], last register, grant one-hot). All memory muxing and the response pipeline stay in the top module.

Test Plan:
- I only: i_read = 1, i_address = 0x004 (memory preloaded with 0x00000013 at 0x004) → i_grant = 1 that cycle, mem_read = 1, mem_address = 0x004; next cycle i_resp_valid = 1, i_resp_data = 0x00000013.
- Conflict after reset: i_read = d_read = 1 held for 4 cycles → grant order I, D, I, D; each resp_valid lands on the matching side 1 cycle later; i_grants = 2, d_grants = 2.
- Store then load:
  - d_write, d_address = 0x010, d_in_data = 0xDEADBEEF → mem_write = 1; next cycle d_resp_valid = 1, d_resp_data = 0.
  - Then d_read at 0x010 → d_resp_data = 0xDEADBEEF.
- Read + write together: d_read = d_write = 1 at 0x020, data 0x12345678 → only mem_write = 1, mem_read = 0; a subsequent read returns 0x12345678.
- Reset mid-op: grant I in cycle N, reset = 1 in cycle N+1 → i_resp_valid = 0 in N+1, counters = 0; first conflict after reset grants I.
- Idle: no requests for 3 cycles → mem_read = mem_write = 0, mem_address = 0, all resp_valid = 0; cycles counter increments by 3.
